// File: rtl/decode3_8_seq.sv
// Registered 3-to-8 one-hot decoder with valid/ready handshake and a built-in
// scan sequencer that walks codes 0..7 for decoder->encoder loopback self-test.
// Optional feature macro: DECODE_PAR_EN adds in_par/par_err with an even-parity
// check on incoming codes.
//
// state | meaning
// IDLE  | no beat held, ready for input or a scan request
// HOLD  | holding a decoded input beat, acts as a one-deep pipe
// SCAN  | sequencer running, emitting code step%8 for DWELL cycles each

module decode3_8_seq #(
    parameter int DWELL      = 3,
    parameter int SCAN_STEPS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       scan_start,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       scan_busy,
`ifdef DECODE_PAR_EN
    input  logic       in_par,
    output logic       par_err,
`endif
    output logic       scan_done
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [5:0]    STEP_LAST  = 6'(SCAN_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t        state;
    logic [5:0]    step;
    logic [DW-1:0] dwell;
    logic          beat_err;
    logic [7:0]    beat_out;
    logic [5:0]    step_nxt;

    function automatic logic [7:0] onehot(input logic [2:0] code);
        return 8'h01 << code;
    endfunction

`ifdef DECODE_PAR_EN
    assign beat_err = (in_par != ^in);
`else
    assign beat_err = 1'b0;
`endif

    // A parity-failing beat is still delivered, but with no line selected.
    assign beat_out = beat_err ? 8'h00 : onehot(in);
    assign step_nxt = step + 6'd1;

    // Ready depends only on state and the sink, never on in_valid.
    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign scan_busy = (state == SCAN);

    // Main sequencer: state, output beat, scan step/dwell counters and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out       <= 8'h00;
            out_valid <= 1'b0;
            scan_done <= 1'b0;
            step      <= 6'd0;
            dwell     <= '0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out       <= beat_out;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (scan_start) begin
                        out       <= 8'h01;
                        out_valid <= 1'b1;
                        step      <= 6'd0;
                        dwell     <= '0;
                        state     <= SCAN;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            out <= beat_out;
                        end else begin
                            out       <= 8'h00;
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        if (out_ready) begin
                            dwell <= '0;
                            if (step == STEP_LAST) begin
                                out       <= 8'h00;
                                out_valid <= 1'b0;
                                scan_done <= 1'b1;
                                step      <= 6'd0;
                                state     <= IDLE;
                            end else begin
                                step <= step_nxt;
                                out  <= onehot(step_nxt[2:0]);
                            end
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out       <= 8'h00;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DECODE_PAR_EN
    // Error flag travels with the beat it describes; scan beats are always clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            case (state)
                IDLE:    par_err <= in_valid & beat_err;
                HOLD:    if (out_ready) par_err <= in_valid & beat_err;
                default: par_err <= 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_decode3_8_seq.sv
// Directed self-checking bench for decode3_8_seq (DWELL=3, SCAN_STEPS=15).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_decode3_8_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in;
    logic       in_valid;
    logic       in_ready;
    logic       scan_start;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       scan_busy;
    logic       scan_done;
`ifdef DECODE_PAR_EN
    logic       in_par;
    logic       par_err;
    logic       par_flip;
    assign in_par = (^in) ^ par_flip;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_val;

    always #5 clk = ~clk;

    decode3_8_seq #(.DWELL(3), .SCAN_STEPS(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .scan_start (scan_start),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .scan_busy  (scan_busy),
`ifdef DECODE_PAR_EN
        .in_par     (in_par),
        .par_err    (par_err),
`endif
        .scan_done  (scan_done)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, expv, $time);
        end
    endtask

    initial begin
        rst = 1'b1; in = 3'd0; in_valid = 1'b0; scan_start = 1'b0; out_ready = 1'b1;
`ifdef DECODE_PAR_EN
        par_flip = 1'b0;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out", out, 8'h00);
        check("rst_out_valid", {7'd0, out_valid}, 8'h00);
        check("rst_scan_busy", {7'd0, scan_busy}, 8'h00);
        check("rst_scan_done", {7'd0, scan_done}, 8'h00);
        check("rst_in_ready", {7'd0, in_ready}, 8'h01);
        rst = 1'b0;

        // 1: single beat, IN=5
        @(negedge clk);
        in = 3'd5; in_valid = 1'b1;
        @(negedge clk);
        check("t1_out", out, 8'h20);
        check("t1_valid", {7'd0, out_valid}, 8'h01);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_out_clr", out, 8'h00);
        check("t1_valid_clr", {7'd0, out_valid}, 8'h00);

        // 2: stream 0..7 with a 3-cycle stall while code 3 is held
        in = 3'd0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_val = 8'h01 << i;
            check("t2_out", out, exp_val);
            check("t2_valid", {7'd0, out_valid}, 8'h01);
            if (i < 7) in = 3'(i + 1);
            else       in_valid = 1'b0;
            if (i == 3) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check("t2_stall_in_ready", {7'd0, in_ready}, 8'h00);
                    @(negedge clk);
                    check("t2_stall_out", out, 8'h08);
                    check("t2_stall_valid", {7'd0, out_valid}, 8'h01);
                end
                out_ready = 1'b1;
                #1;
                check("t2_resume_in_ready", {7'd0, in_ready}, 8'h01);
            end
        end
        @(negedge clk);
        check("t2_end_valid", {7'd0, out_valid}, 8'h00);

        // 3: full scan run, 15 beats x 3 cycles
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        for (int c = 0; c < 45; c++) begin
            exp_val = 8'h01 << ((c / 3) % 8);
            check("t3_out", out, exp_val);
            check("t3_busy", {7'd0, scan_busy}, 8'h01);
            check("t3_in_ready", {7'd0, in_ready}, 8'h00);
            check("t3_done_low", {7'd0, scan_done}, 8'h00);
            @(negedge clk);
        end
        check("t3_done_pulse", {7'd0, scan_done}, 8'h01);
        check("t3_end_out", out, 8'h00);
        check("t3_end_valid", {7'd0, out_valid}, 8'h00);
        check("t3_end_busy", {7'd0, scan_busy}, 8'h00);
        @(negedge clk);
        check("t3_done_once", {7'd0, scan_done}, 8'h00);

        // 4: reset during scan at step 6
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (18) @(negedge clk);
        check("t4_step6_out", out, 8'h40);
        rst = 1'b1;
        #1;
        check("t4_rst_out", out, 8'h00);
        check("t4_rst_valid", {7'd0, out_valid}, 8'h00);
        check("t4_rst_busy", {7'd0, scan_busy}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        in = 3'd2; in_valid = 1'b1;
        @(negedge clk);
        check("t4_after_out", out, 8'h04);
        check("t4_after_busy", {7'd0, scan_busy}, 8'h00);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_idle_valid", {7'd0, out_valid}, 8'h00);

        // 5: input wins over simultaneous scan request
        in = 3'd3; in_valid = 1'b1; scan_start = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; scan_start = 1'b0;
        check("t5_out", out, 8'h08);
        check("t5_busy", {7'd0, scan_busy}, 8'h00);
        @(negedge clk);
        check("t5_busy_after", {7'd0, scan_busy}, 8'h00);
        check("t5_valid_after", {7'd0, out_valid}, 8'h00);

`ifdef DECODE_PAR_EN
        // 6: parity error beat then a clean beat
        in = 3'd3; in_valid = 1'b1; par_flip = 1'b1;
        @(negedge clk);
        check("t6_err_out", out, 8'h00);
        check("t6_err_valid", {7'd0, out_valid}, 8'h01);
        check("t6_err_flag", {7'd0, par_err}, 8'h01);
        par_flip = 1'b0;
        @(negedge clk);
        check("t6_ok_out", out, 8'h08);
        check("t6_ok_flag", {7'd0, par_err}, 8'h00);
        in_valid = 1'b0;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
